// File: rtl/ram_pkg.sv
// ram_pkg: shared definitions for the cache-block BRAM controller.
//   state_t          - controller FSM states
//   DEF_*            - default values for the controller parameters
package ram_pkg;

  localparam int DEF_WORD_W      = 32;
  localparam int DEF_BLOCK_WORDS = 8;
  localparam int DEF_ADDR_W      = 11;
  localparam int DEF_RD_LAT      = 1;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_DRAIN,
    ST_DONE
  } state_t;

endpackage

// File: rtl/ram_rd_pipe.sv
// ram_rd_pipe: RD_LAT-deep delay line that tracks outstanding BRAM reads.
// A read issued with word index k in cycle c appears on out_valid/out_idx in
// cycle c+RD_LAT, which is exactly when the BRAM returns that word.
//   clk, rst   - clock, asynchronous active-high reset
//   in_valid   - a read word address is being issued this cycle
//   in_idx     - word index of that read
//   out_valid  - the BRAM output word is valid this cycle
//   out_idx    - block word index the BRAM output belongs to
module ram_rd_pipe
  import ram_pkg::*;
#(
  parameter int IDX_W  = 3,
  parameter int RD_LAT = DEF_RD_LAT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [IDX_W-1:0] in_idx,
  output logic             out_valid,
  output logic [IDX_W-1:0] out_idx
);

  logic [RD_LAT-1:0]            vld;
  logic [RD_LAT-1:0][IDX_W-1:0] idx_sr;

  // Valid bits are reset so an aborted read can never be captured later.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld <= '0;
    end else begin
      vld[0] <= in_valid;
      for (int i = 1; i < RD_LAT; i++) begin
        vld[i] <= vld[i-1];
      end
    end
  end

  // Index stages are only qualified by vld, so they carry no reset.
  always_ff @(posedge clk) begin
    idx_sr[0] <= in_idx;
    for (int i = 1; i < RD_LAT; i++) begin
      idx_sr[i] <= idx_sr[i-1];
    end
  end

  assign out_valid = vld[RD_LAT-1];
  assign out_idx   = idx_sr[RD_LAT-1];

endmodule

// File: rtl/ram_block_ctrl.sv
// ram_block_ctrl: moves whole cache blocks between a requester and a
// single-port word-wide BRAM. A request is latched in IDLE, then one word
// address is issued per cycle in ascending order; reads wait RD_LAT cycles
// for the last word before the assembled block is published on rdata.
//   clk, rst            - clock, asynchronous active-high reset
//   req/req_we          - block request (sampled when req_ready), 1=write
//   req_addr/req_wdata  - block address and block write data
//   req_ready           - idle; a request is accepted this cycle if req=1
//   done                - one-cycle completion pulse
//   rdata               - last block read (word k at [k*WORD_W +: WORD_W])
//   bram_en/bram_we     - BRAM enable / write enable
//   bram_addr/bram_din  - BRAM word address {block, index} / write word
//   bram_dout           - BRAM read word, valid RD_LAT cycles after address
module ram_block_ctrl
  import ram_pkg::*;
#(
  parameter  int WORD_W      = DEF_WORD_W,
  parameter  int BLOCK_WORDS = DEF_BLOCK_WORDS,
  parameter  int ADDR_W      = DEF_ADDR_W,
  parameter  int RD_LAT      = DEF_RD_LAT,
  localparam int IDX_W       = $clog2(BLOCK_WORDS),
  localparam int BLK_W       = WORD_W * BLOCK_WORDS
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    req,
  input  logic                    req_we,
  input  logic [ADDR_W-1:0]       req_addr,
  input  logic [BLK_W-1:0]        req_wdata,
  output logic                    req_ready,
  output logic                    done,
  output logic [BLK_W-1:0]        rdata,
  output logic                    bram_en,
  output logic                    bram_we,
  output logic [ADDR_W+IDX_W-1:0] bram_addr,
  output logic [WORD_W-1:0]       bram_din,
  input  logic [WORD_W-1:0]       bram_dout
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(BLOCK_WORDS - 1);

  typedef logic [BLOCK_WORDS-1:0][WORD_W-1:0] block_t;

  state_t            state, state_next;
  logic [IDX_W-1:0]  idx;
  logic              we_q;
  logic [ADDR_W-1:0] addr_q;
  block_t            wdata_q;
  block_t            rbuf, rbuf_next;
  block_t            rdata_q;
  logic              accept;
  logic              last_word;
  logic              cap_valid;
  logic [IDX_W-1:0]  cap_idx;

  assign accept    = (state == ST_IDLE) && req;
  assign last_word = (idx == LAST_IDX);

  // ---------------- FSM: state register ----------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_next;
  end

  // ---------------- FSM: next state ----------------
  // NOTE: combinational blocks use blocking '=' and assign a default first,
  // so every path drives every output and no latch is inferred.
  always_comb begin
    state_next = state;
    unique case (state)
      ST_IDLE:  if (req) state_next = ST_ISSUE;
      ST_ISSUE: if (last_word) state_next = we_q ? ST_DONE : ST_DRAIN;
      // The read pipe reports the last word exactly RD_LAT cycles after it
      // was issued, which is what bounds the drain.
      ST_DRAIN: if (cap_valid && cap_idx == LAST_IDX) state_next = ST_DONE;
      ST_DONE:  state_next = ST_IDLE;
      default:  state_next = ST_IDLE;
    endcase
  end

  // ---------------- FSM: outputs ----------------
  always_comb begin
    req_ready = 1'b0;
    done      = 1'b0;
    bram_en   = 1'b0;
    bram_we   = 1'b0;
    unique case (state)
      ST_IDLE:  req_ready = 1'b1;
      ST_ISSUE: begin
        bram_en = 1'b1;
        bram_we = we_q;
      end
      ST_DRAIN: ;
      ST_DONE:  done = 1'b1;
      default:  ;
    endcase
  end

  assign bram_addr = {addr_q, idx};
  assign bram_din  = wdata_q[idx];
  assign rdata     = rdata_q;

  // ---------------- request latch, word index, published block ----------------
  // NOTE: sequential state uses non-blocking '<=' so all registers update
  // from the same pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx     <= '0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
    end else begin
      if (accept) begin
        we_q    <= req_we;
        addr_q  <= req_addr;
        wdata_q <= req_wdata;
        idx     <= '0;
      end else if (state == ST_ISSUE && !last_word) begin
        // Holds at the last index instead of wrapping; cleared on accept.
        idx <= idx + 1'b1;
      end
      // The final word lands in the same edge that enters DONE, so publish
      // the merged view rather than the buffer register.
      if (state == ST_DRAIN && state_next == ST_DONE) begin
        rdata_q <= rbuf_next;
      end
    end
  end

  // ---------------- read capture ----------------
  ram_rd_pipe #(
    .IDX_W  (IDX_W),
    .RD_LAT (RD_LAT)
  ) u_rd_pipe (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (state == ST_ISSUE && !we_q),
    .in_idx    (idx),
    .out_valid (cap_valid),
    .out_idx   (cap_idx)
  );

  always_comb begin
    rbuf_next = rbuf;
    if (cap_valid) rbuf_next[cap_idx] = bram_dout;
  end

  // NOTE: the capture buffer is storage, not control: it has no reset. Every
  // word is rewritten by a read before the buffer is ever published.
  always_ff @(posedge clk) begin
    rbuf <= rbuf_next;
  end

endmodule

// File: tb/tb_ram_block_ctrl.sv
// tb_ram_block_ctrl: self-checking bench for ram_block_ctrl.
// Two instances (RD_LAT=1 and RD_LAT=3) each drive their own BRAM model.
// A per-instance transaction model expands every accepted request into the
// expected cycle-by-cycle BRAM activity and is compared on every falling
// edge; directed tests add hand-computed latencies, addresses and data.
module tb_ram_block_ctrl;

  localparam int WW  = 32;
  localparam int BW  = 8;
  localparam int AW  = 11;
  localparam int IW  = 3;
  localparam int BLK = WW * BW;
  localparam int BA  = AW + IW;

  typedef struct {
    logic          en;
    logic          we;
    logic [BA-1:0] addr;
    logic [WW-1:0] din;
    logic          done;
    logic          rd_done;
    logic [BLK-1:0] blk;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b0;

  logic           req       [2];
  logic           req_we    [2];
  logic [AW-1:0]  req_addr  [2];
  logic [BLK-1:0] req_wdata [2];
  logic           req_ready [2];
  logic           done      [2];
  logic [BLK-1:0] rdata     [2];
  logic           bram_en   [2];
  logic           bram_we   [2];
  logic [BA-1:0]  bram_addr [2];
  logic [WW-1:0]  bram_din  [2];
  logic [WW-1:0]  bram_dout [2];

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [BLK-1:0] act, input logic [BLK-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [WW-1:0] init_word(input int i);
    return 32'hA500_0000 | 32'(i);
  endfunction

  function automatic logic [BLK-1:0] pattern(input logic [WW-1:0] base);
    logic [BLK-1:0] b;
    for (int k = 0; k < BW; k++) b[k*WW +: WW] = base + WW'(k);
    return b;
  endfunction

  function automatic logic [WW-1:0] word_of(input logic [BLK-1:0] b, input int k);
    return b[k*WW +: WW];
  endfunction

  for (genvar g = 0; g < 2; g++) begin : inst
    localparam int LAT = (g == 0) ? 1 : 3;

    ram_block_ctrl #(
      .WORD_W      (WW),
      .BLOCK_WORDS (BW),
      .ADDR_W      (AW),
      .RD_LAT      (LAT)
    ) dut (
      .clk       (clk),
      .rst       (rst),
      .req       (req[g]),
      .req_we    (req_we[g]),
      .req_addr  (req_addr[g]),
      .req_wdata (req_wdata[g]),
      .req_ready (req_ready[g]),
      .done      (done[g]),
      .rdata     (rdata[g]),
      .bram_en   (bram_en[g]),
      .bram_we   (bram_we[g]),
      .bram_addr (bram_addr[g]),
      .bram_din  (bram_din[g]),
      .bram_dout (bram_dout[g])
    );

    // BRAM model: synchronous write, read data valid LAT cycles later.
    logic [WW-1:0] mem     [1 << BA];
    logic [WW-1:0] ref_mem [1 << BA];
    logic [WW-1:0] rd_pipe [LAT];
    exp_t          q [$];
    logic [BLK-1:0] exp_rdata;

    initial begin
      for (int i = 0; i < (1 << BA); i++) begin
        mem[i]     = init_word(i);
        ref_mem[i] = init_word(i);
      end
      exp_rdata = '0;
    end

    always @(posedge clk) begin
      if (bram_en[g] && bram_we[g]) mem[bram_addr[g]] <= bram_din[g];
      rd_pipe[0] <= (bram_en[g] && !bram_we[g]) ? mem[bram_addr[g]] : 32'hDEAD_BEEF;
      for (int i = 1; i < LAT; i++) rd_pipe[i] <= rd_pipe[i-1];
    end

    assign bram_dout[g] = rd_pipe[LAT-1];

    // Transaction model and per-cycle comparison.
    always @(negedge clk) begin : cmp
      exp_t e;
      logic [BLK-1:0] b;
      if (rst) begin
        q.delete();
        exp_rdata = '0;
        check($sformatf("i%0d_rst_ready", g), req_ready[g], 1'b1);
        check($sformatf("i%0d_rst_done", g), done[g], 1'b0);
        check($sformatf("i%0d_rst_en", g), bram_en[g], 1'b0);
        check($sformatf("i%0d_rst_we", g), bram_we[g], 1'b0);
        check($sformatf("i%0d_rst_rdata", g), rdata[g], '0);
      end else if (q.size() > 0) begin
        e = q.pop_front();
        check($sformatf("i%0d_ready", g), req_ready[g], 1'b0);
        check($sformatf("i%0d_en", g), bram_en[g], e.en);
        check($sformatf("i%0d_we", g), bram_we[g], e.we);
        check($sformatf("i%0d_done", g), done[g], e.done);
        if (e.en) check($sformatf("i%0d_addr", g), bram_addr[g], e.addr);
        if (e.en && e.we) begin
          check($sformatf("i%0d_din", g), bram_din[g], e.din);
          ref_mem[e.addr] = e.din;
        end
        if (e.rd_done) exp_rdata = e.blk;
        check($sformatf("i%0d_rdata", g), rdata[g], exp_rdata);
      end else begin
        check($sformatf("i%0d_idle_ready", g), req_ready[g], 1'b1);
        check($sformatf("i%0d_idle_done", g), done[g], 1'b0);
        check($sformatf("i%0d_idle_en", g), bram_en[g], 1'b0);
        check($sformatf("i%0d_idle_we", g), bram_we[g], 1'b0);
        check($sformatf("i%0d_idle_rdata", g), rdata[g], exp_rdata);
        if (req[g]) begin
          b = '0;
          for (int k = 0; k < BW; k++) begin
            if (!req_we[g]) b[k*WW +: WW] = ref_mem[{req_addr[g], IW'(k)}];
            e = '{en: 1'b1, we: req_we[g], addr: {req_addr[g], IW'(k)},
                  din: req_wdata[g][k*WW +: WW], done: 1'b0, rd_done: 1'b0, blk: '0};
            q.push_back(e);
          end
          if (!req_we[g]) begin
            for (int k = 0; k < LAT; k++) begin
              e = '{en: 1'b0, we: 1'b0, addr: '0, din: '0, done: 1'b0, rd_done: 1'b0, blk: '0};
              q.push_back(e);
            end
          end
          e = '{en: 1'b0, we: 1'b0, addr: '0, din: '0, done: 1'b1, rd_done: !req_we[g], blk: b};
          q.push_back(e);
        end
      end
    end
  end

  // Presents a request from the next post-edge point and returns just after
  // the accepting edge, with the request inputs scrambled.
  task automatic start(input int g, input logic we, input logic [AW-1:0] a, input logic [BLK-1:0] d);
    int n;
    n = 0;
    @(posedge clk); #1;
    while (!req_ready[g] && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    check($sformatf("i%0d_ready_before_req", g), req_ready[g], 1'b1);
    req_we[g]    = we;
    req_addr[g]  = a;
    req_wdata[g] = d;
    req[g]       = 1'b1;
    @(posedge clk); #1;
    req[g]       = 1'b0;
    req_we[g]    = ~we;
    req_addr[g]  = ~a;
    req_wdata[g] = ~d;
  endtask

  // Counts falling edges after the accepting edge until done (-1 on timeout).
  task automatic wait_done(input int g, output int lat, output int we_cnt,
                           output logic [BA-1:0] first_a, output logic [BA-1:0] last_a);
    bit seen;
    lat = -1; we_cnt = 0; first_a = '0; last_a = '0; seen = 1'b0;
    for (int n = 1; n <= 60; n++) begin
      @(negedge clk);
      if (bram_en[g]) begin
        if (!seen) first_a = bram_addr[g];
        seen   = 1'b1;
        last_a = bram_addr[g];
      end
      if (bram_we[g]) we_cnt++;
      if (done[g]) begin
        lat = n;
        break;
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1);
  end

  initial begin
    int lat, wc, dn;
    logic [BA-1:0] fa, la;
    for (int g = 0; g < 2; g++) begin
      req[g] = 1'b0; req_we[g] = 1'b0; req_addr[g] = '0; req_wdata[g] = '0;
    end

    // Reset state
    #2 rst = 1'b1;
    #1;
    check("reset_ready", req_ready[0], 1'b1);
    check("reset_done", done[0], 1'b0);
    check("reset_bram_en", bram_en[0], 1'b0);
    check("reset_bram_we", bram_we[0], 1'b0);
    check("reset_rdata", rdata[0], '0);
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // Write block 0x005
    start(0, 1'b1, 11'h005, pattern(32'h1111_1100));
    wait_done(0, lat, wc, fa, la);
    check("wr_latency", lat, 9);
    check("wr_we_cycles", wc, 8);
    check("wr_first_addr", fa, 14'h028);
    check("wr_last_addr", la, 14'h02F);
    for (int k = 0; k < BW; k++) check($sformatf("wr_mem_%0d", k), inst[0].mem[14'h028 + k], 32'h1111_1100 + k);

    // Read block 0x005
    start(0, 1'b0, 11'h005, '0);
    wait_done(0, lat, wc, fa, la);
    check("rd_latency", lat, 10);
    check("rd_we_cycles", wc, 0);
    for (int k = 0; k < BW; k++) check($sformatf("rd_word_%0d", k), word_of(rdata[0], k), 32'h1111_1100 + k);

    // Back-to-back with req held; inputs change while busy
    @(posedge clk); #1;
    req_we[0] = 1'b1; req_addr[0] = 11'h010; req_wdata[0] = pattern(32'h2222_0000); req[0] = 1'b1;
    @(posedge clk); #1;
    req_addr[0] = 11'h011; req_wdata[0] = pattern(32'h3333_0000);
    wait_done(0, lat, wc, fa, la);
    check("b2b_first_latency", lat, 9);
    check("b2b_first_addr", fa, 14'h080);
    @(negedge clk);
    check("b2b_idle_gap_ready", req_ready[0], 1'b1);
    wait_done(0, lat, wc, fa, la);
    req[0] = 1'b0;
    check("b2b_second_latency", lat, 9);
    check("b2b_second_addr", fa, 14'h088);
    for (int k = 0; k < BW; k++) begin
      check($sformatf("b2b_mem_a%0d", k), inst[0].mem[14'h080 + k], 32'h2222_0000 + k);
      check($sformatf("b2b_mem_b%0d", k), inst[0].mem[14'h088 + k], 32'h3333_0000 + k);
    end

    // Reset during ISSUE index 4 of a write
    start(0, 1'b1, 11'h020, pattern(32'hCAFE_0000));
    repeat (4) @(posedge clk);
    #1 rst = 1'b1;
    #1;
    check("abort_we_drop", bram_we[0], 1'b0);
    check("abort_en_drop", bram_en[0], 1'b0);
    check("abort_ready", req_ready[0], 1'b1);
    check("abort_rdata", rdata[0], '0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    dn = 0;
    repeat (12) begin
      @(negedge clk);
      if (done[0]) dn++;
    end
    check("abort_no_done", dn, 0);
    for (int k = 0; k < BW; k++) begin
      if (k < 4) check($sformatf("abort_mem_%0d", k), inst[0].mem[14'h100 + k], 32'hCAFE_0000 + k);
      else       check($sformatf("abort_mem_%0d", k), inst[0].mem[14'h100 + k], 32'hA500_0100 + k);
    end

    // Read back the partially written block
    start(0, 1'b0, 11'h020, '0);
    wait_done(0, lat, wc, fa, la);
    check("partial_rd_latency", lat, 10);
    check("partial_rd_word3", word_of(rdata[0], 3), 32'hCAFE_0003);
    check("partial_rd_word4", word_of(rdata[0], 4), 32'hA500_0104);

    // RD_LAT=3 instance: read top block, then write and read it back
    start(1, 1'b0, 11'h7FF, '0);
    wait_done(1, lat, wc, fa, la);
    check("lat3_rd_latency", lat, 12);
    check("lat3_first_addr", fa, 14'h3FF8);
    check("lat3_last_addr", la, 14'h3FFF);
    for (int k = 0; k < BW; k++) check($sformatf("lat3_rd_word_%0d", k), word_of(rdata[1], k), 32'hA500_3FF8 + k);
    start(1, 1'b1, 11'h7FF, pattern(32'h4444_0010));
    wait_done(1, lat, wc, fa, la);
    check("lat3_wr_latency", lat, 9);
    check("lat3_rdata_hold", word_of(rdata[1], 0), 32'hA500_3FF8);
    start(1, 1'b0, 11'h7FF, '0);
    wait_done(1, lat, wc, fa, la);
    check("lat3_rd2_latency", lat, 12);
    for (int k = 0; k < BW; k++) check($sformatf("lat3_rd2_word_%0d", k), word_of(rdata[1], k), 32'h4444_0010 + k);

    repeat (4) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/ram_block_ctrl.md
RAM_BLOCK_CTRL -- requirements
Module: ram_block_ctrl

Interface
REQ-001 SHALL have parameter WORD_W, default 32, BRAM word width in bits.
REQ-002 SHALL have parameter BLOCK_WORDS, default 8, words per cache block; power of two, at least 2.
REQ-003 SHALL have parameter ADDR_W, default 11, block address width.
REQ-004 SHALL have parameter RD_LAT, default 1, BRAM read latency in cycles; range 1..4.
REQ-005 SHALL have localparam IDX_W = log2(BLOCK_WORDS) and BLK_W = WORD_W*BLOCK_WORDS.
REQ-006 SHALL use one clock and an asynchronous, active-high reset: clk  in  1  rising-edge clock.
REQ-007 rst  in  1  asynchronous active-high reset.
REQ-008 req  in  1  block request; sampled only when req_ready=1.
REQ-009 req_we  in  1  1=write block, 0=read block.
REQ-010 req_addr  in  ADDR_W  block address.
REQ-011 req_wdata  in  BLK_W  block to write; word k = bits [k*WORD_W +: WORD_W].
REQ-012 req_ready  out  1  controller idle, request accepted this cycle if req=1.
REQ-013 done  out  1  one-cycle completion pulse.
REQ-014 rdata  out  BLK_W  last block read, word k at bits [k*WORD_W +: WORD_W].
REQ-015 bram_en  out  1  BRAM enable.
REQ-016 bram_we  out  1  BRAM write enable.
REQ-017 bram_addr  out  ADDR_W+IDX_W  word address {block addr, word index}.
REQ-018 bram_din  out  WORD_W  write word.
REQ-019 bram_dout  in  WORD_W  read word, valid RD_LAT cycles after its address.

Function
REQ-020 SHALL implement states IDLE, ISSUE, DRAIN, DONE; req_ready=1 only in IDLE.
REQ-021 IDLE with req=1 SHALL latch req_we, req_addr, req_wdata and go to ISSUE; later input changes SHALL be ignored until the next IDLE.
REQ-022 ISSUE SHALL last exactly BLOCK_WORDS cycles, index 0..BLOCK_WORDS-1 ascending, bram_en=1, bram_addr={latched addr, index}.
REQ-023 Write in ISSUE: bram_we=1, bram_din=latched word[index]; after the last word go to DONE (no DRAIN).
REQ-024 Read in ISSUE: bram_we=0; after the last word go to DRAIN for RD_LAT cycles, bram_en=0.
REQ-025 Read capture: the word returned for index k SHALL be stored into an internal buffer word k exactly RD_LAT cycles after issue; unaddressed words are untouched.
REQ-026 DONE SHALL last one cycle with done=1, then return to IDLE; back-to-back requests therefore have one IDLE cycle minimum.
REQ-027 Latency from accept edge to done: write BLOCK_WORDS+1 cycles, read BLOCK_WORDS+RD_LAT+1 cycles.
REQ-028 rdata SHALL update only on entry to DONE of a read, holding the complete block; it SHALL stay stable through writes and idle.
REQ-029 Outside ISSUE, bram_en=0 and bram_we=0; bram_addr and bram_din are don't-care.
REQ-030 The word index counter SHALL be IDX_W bits and SHALL NOT wrap within a transfer.

Reset
REQ-031 Reset SHALL asynchronously force IDLE, req_ready=1, done=0, bram_en=0, bram_we=0, rdata=0, index=0.
REQ-032 Reset mid-transfer SHALL abort it: no done pulse, rdata keeps the reset value, no further BRAM writes.

Structure
REQ-033 Package ram_pkg SHALL hold the state enum and the default parameter constants.
REQ-034 Sub-module ram_rd_pipe SHALL implement the RD_LAT-deep valid/index delay line that drives read capture.

Verification (defaults: WORD_W=32, BLOCK_WORDS=8, ADDR_W=11, RD_LAT=1)
REQ-035 Write req_addr=0x005, words 0x11111100+k -> bram_addr 0x028..0x02F, bram_we=1 for 8 cycles, done 9 cycles after accept.
REQ-036 Read 0x005 after REQ-035 -> rdata word k=0x11111100+k, done 10 cycles after accept.
REQ-037 RD_LAT=3 read of 0x7FF -> addresses 0x3FF8..0x3FFF, done 12 cycles after accept, correct data.
REQ-038 req held high for two blocks back-to-back -> second accepted cycle after done, req ignored while busy.
REQ-039 rst pulsed at ISSUE cycle 4 of a write -> bram_we drops immediately, no done, words 4..7 unwritten.
